// File: rtl/alu_seq_if.sv
// Instruction request and result response handshakes of the ALU sequencer.
// master = the issuing stage, slave = the sequencer.
interface alu_seq_if #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
);
    logic             instr_valid;
    logic             instr_ready;
    logic [OPW-1:0]   opcode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic [3:0]       res_status;
    logic             res_err;

    modport master (
        output instr_valid, opcode, op_a, op_b, res_ready,
        input  instr_ready, res_valid, res_lo, res_hi, res_status, res_err
    );

    modport slave (
        input  instr_valid, opcode, op_a, op_b, res_ready,
        output instr_ready, res_valid, res_lo, res_hi, res_status, res_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Control stage for the 16-bit ALU: accepts one op, sequences the ALU
// strobes over LOAD/EXEC/CAPT and returns the captured result.
module alu_sequencer #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_seq_if.slave         bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             a_enable,
    output logic             acc_enable,
    output logic             addsub,
    output logic             add_ctrl,
    output logic             xor_ctrl,
    output logic             mul_out_ctrl,
    input  logic [WIDTH-1:0] acc_out,
    input  logic [WIDTH-1:0] mul_acc_out,
    input  logic [3:0]       status_reg,
    output logic [CNT_W-1:0] op_count
);
    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_XOR = OPW'(2);
    localparam logic [OPW-1:0] OP_MUL = OPW'(3);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXEC,
        CAPT,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] b_q;
    logic             ready_en;
    logic             accept;
    logic             legal;
    logic             res_done;
    logic             is_add;
    logic             is_sub;
    logic             is_xor;
    logic             is_mul;

    assign is_add = (op_q == OP_ADD);
    assign is_sub = (op_q == OP_SUB);
    assign is_xor = (op_q == OP_XOR);
    assign is_mul = (op_q == OP_MUL);

    assign legal = (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB) ||
                   (bus.opcode == OP_XOR) || (bus.opcode == OP_MUL);

    assign accept   = bus.instr_valid & bus.instr_ready;
    assign res_done = bus.res_valid & bus.res_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.instr_ready = 1'b0;
        bus.res_valid   = 1'b0;
        a_enable        = 1'b0;
        acc_enable      = 1'b0;
        addsub          = 1'b0;
        add_ctrl        = 1'b0;
        xor_ctrl        = 1'b0;
        mul_out_ctrl    = 1'b0;
        alu_b           = '0;
        unique case (state)
            IDLE: begin
                // ready_en keeps instr_ready low until the first edge after reset
                bus.instr_ready = ready_en;
                if (accept) begin
                    state_nxt = legal ? LOAD : RESP;
                end
            end
            LOAD: begin
                a_enable  = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                alu_b      = b_q;
                acc_enable = 1'b1;
                unique case (1'b1)
                    is_add:  add_ctrl = 1'b1;
                    is_sub:  begin
                        add_ctrl = 1'b1;
                        addsub   = 1'b1;
                    end
                    is_xor:  xor_ctrl = 1'b1;
                    is_mul:  mul_out_ctrl = 1'b1;
                    default: ;
                endcase
                state_nxt = CAPT;
            end
            CAPT: begin
                state_nxt = RESP;
            end
            RESP: begin
                bus.res_valid = 1'b1;
                if (res_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en       <= 1'b0;
            op_q           <= '0;
            alu_a          <= '0;
            b_q            <= '0;
            bus.res_lo     <= '0;
            bus.res_hi     <= '0;
            bus.res_status <= '0;
            bus.res_err    <= 1'b0;
            op_count       <= '0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                op_q <= bus.opcode;
                if (legal) begin
                    alu_a       <= bus.op_a;
                    b_q         <= bus.op_b;
                    bus.res_err <= 1'b0;
                end else begin
                    bus.res_err    <= 1'b1;
                    bus.res_lo     <= '0;
                    bus.res_hi     <= '0;
                    bus.res_status <= '0;
                end
            end
            // status_reg is only meaningful while the adder drives the bus
            if (state == EXEC) begin
                bus.res_status <= (is_add || is_sub) ? status_reg : 4'd0;
            end
            if (state == CAPT) begin
                bus.res_lo <= is_mul ? mul_acc_out : acc_out;
                bus.res_hi <= is_mul ? acc_out : '0;
            end
            if (res_done) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ALU stub, directed table, random ops against
// an arithmetic reference model, backpressure and async reset cases.
module tb_alu_sequencer;
    logic        clk;
    logic        rst;
    logic [15:0] alu_a, alu_b;
    logic        a_enable, acc_enable, addsub;
    logic        add_ctrl, xor_ctrl, mul_out_ctrl;
    logic [15:0] acc_out, mul_acc_out;
    logic [3:0]  status_reg;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_err    = 0;
    logic [15:0] exp_count = 0;

    alu_seq_if #(.WIDTH(16), .OPW(3)) bus ();

    alu_sequencer #(.WIDTH(16), .OPW(3), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .a_enable     (a_enable),
        .acc_enable   (acc_enable),
        .addsub       (addsub),
        .add_ctrl     (add_ctrl),
        .xor_ctrl     (xor_ctrl),
        .mul_out_ctrl (mul_out_ctrl),
        .acc_out      (acc_out),
        .mul_acc_out  (mul_acc_out),
        .status_reg   (status_reg),
        .op_count     (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub: A register, accumulator pair, combinational adder status
    logic [15:0] areg;
    logic [15:0] bb;
    logic [16:0] t;
    logic [31:0] prod;

    always_comb begin
        bb   = addsub ? ~alu_b : alu_b;
        t    = {1'b0, areg} + {1'b0, bb} + {16'd0, addsub};
        prod = {16'd0, areg} * {16'd0, alu_b};
        status_reg = {t[15], t[15:0] == 16'd0, t[16],
                      (areg[15] == bb[15]) && (t[15] != areg[15])};
    end

    always_ff @(posedge clk) begin
        if (a_enable) areg <= alu_a;
        if (acc_enable) begin
            if (add_ctrl) acc_out <= t[15:0];
            else if (xor_ctrl) acc_out <= areg ^ alu_b;
            else if (mul_out_ctrl) begin
                acc_out     <= prod[31:16];
                mul_acc_out <= prod[15:0];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Result of one operation from the arithmetic definitions
    task automatic ref_op(input logic [2:0] op, input logic [15:0] a, b,
                          output logic [15:0] lo, hi, output logic [3:0] st,
                          output logic err);
        int unsigned s;
        logic c, v;
        lo = 0; hi = 0; st = 0; err = 0;
        case (op)
            3'd0: begin
                s  = a + b;
                lo = s[15:0];
                c  = s > 32'hFFFF;
                v  = (a[15] == b[15]) && (lo[15] != a[15]);
                st = {lo[15], lo == 0, c, v};
            end
            3'd1: begin
                lo = a - b;
                c  = a >= b;
                v  = (a[15] != b[15]) && (lo[15] != a[15]);
                st = {lo[15], lo == 0, c, v};
            end
            3'd2: lo = a ^ b;
            3'd3: {hi, lo} = a * b;
            default: err = 1;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [15:0] a, b,
                          input int hold, input logic [15:0] e_lo, e_hi,
                          input logic e_err, input string tag);
        logic [15:0] m_lo, m_hi;
        logic [3:0]  m_st, ex_st;
        logic        m_err, lg;
        int lat, w, bad, unst;
        int na, nacc, nadd, nsub, nxor, nmul;
        ref_op(op, a, b, m_lo, m_hi, m_st, m_err);
        lg = (op < 3'd4);
        w = 0;
        while (!bus.instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, " instr_ready"}, 32'(bus.instr_ready), 1);
        bus.instr_valid = 1; bus.opcode = op; bus.op_a = a; bus.op_b = b;
        @(posedge clk); #1;
        bus.instr_valid = 0;
        bus.opcode = 3'($urandom); bus.op_a = 16'($urandom);
        bus.op_b = 16'($urandom);
        lat = 1; bad = 0; ex_st = 0;
        na = 0; nacc = 0; nadd = 0; nsub = 0; nxor = 0; nmul = 0;
        while (!bus.res_valid && lat < 20) begin
            na += 32'(a_enable); nacc += 32'(acc_enable);
            nadd += 32'(add_ctrl); nsub += 32'(addsub);
            nxor += 32'(xor_ctrl); nmul += 32'(mul_out_ctrl);
            if (32'(add_ctrl) + 32'(xor_ctrl) + 32'(mul_out_ctrl) > 1) bad++;
            if (!acc_enable && alu_b != 0) bad++;
            if (bus.instr_ready) bad++;
            if (acc_enable) ex_st = status_reg;
            @(posedge clk); #1;
            lat++;
        end
        if ({a_enable, acc_enable, addsub, add_ctrl, xor_ctrl,
             mul_out_ctrl} != 0 || bus.instr_ready) bad++;
        check({tag, " latency"}, lat, lg ? 4 : 1);
        check({tag, " a_enable cycles"}, na, lg ? 1 : 0);
        check({tag, " acc_enable cycles"}, nacc, lg ? 1 : 0);
        check({tag, " add_ctrl cycles"}, nadd, 32'(op == 0 || op == 1));
        check({tag, " addsub cycles"}, nsub, 32'(op == 1));
        check({tag, " xor_ctrl cycles"}, nxor, 32'(op == 2));
        check({tag, " mul_out_ctrl cycles"}, nmul, 32'(op == 3));
        check({tag, " strobe rules"}, bad, 0);
        check({tag, " res_lo"}, 32'(bus.res_lo), 32'(e_lo));
        check({tag, " res_hi"}, 32'(bus.res_hi), 32'(e_hi));
        check({tag, " res_err"}, 32'(bus.res_err), 32'(e_err));
        check({tag, " res_status"}, 32'(bus.res_status), 32'(m_st));
        if (op < 2) check({tag, " status vs EXEC"}, 32'(bus.res_status),
                          32'(ex_st));
        unst = 0;
        if (hold > 0) begin
            bus.instr_valid = 1;
            bus.opcode = 3'd0;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (bus.res_lo != e_lo || bus.res_hi != e_hi ||
                bus.res_err != e_err || bus.res_status != m_st ||
                !bus.res_valid || bus.instr_ready) unst++;
        end
        check({tag, " hold stable"}, unst, 0);
        @(negedge clk);
        bus.instr_valid = 0;
        bus.res_ready = 1;
        @(posedge clk); #1;
        bus.res_ready = 0;
        exp_count++;
        check({tag, " op_count"}, 32'(op_count), 32'(exp_count));
        check({tag, " res_valid drop"}, 32'(bus.res_valid), 0);
        check({tag, " ready after"}, 32'(bus.instr_ready), 1);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a, b;
        int          hold;
        logic [15:0] lo, hi;
        logic        err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [15:0] r_lo, r_hi;
        logic [3:0]  r_st;
        logic        r_err;
        logic [2:0]  rop;
        logic [15:0] ra, rb;

        vecs[0] = '{3'd0, 16'h0003, 16'h0004, 0, 16'h0007, 16'h0000, 1'b0};
        vecs[1] = '{3'd1, 16'h0005, 16'h0007, 1, 16'hFFFE, 16'h0000, 1'b0};
        vecs[2] = '{3'd2, 16'hF0F0, 16'h0FF0, 2, 16'hFF00, 16'h0000, 1'b0};
        vecs[3] = '{3'd3, 16'h0100, 16'h0100, 10, 16'h0000, 16'h0001, 1'b0};
        vecs[4] = '{3'd7, 16'h1234, 16'h5678, 2, 16'h0000, 16'h0000, 1'b1};
        vecs[5] = '{3'd0, 16'h0001, 16'h0002, 0, 16'h0003, 16'h0000, 1'b0};

        rst = 1; bus.instr_valid = 0; bus.res_ready = 0;
        bus.opcode = 0; bus.op_a = 0; bus.op_b = 0;
        #2 rst = 0;
        #1;
        check("reset instr_ready", 32'(bus.instr_ready), 0);
        check("reset res_valid", 32'(bus.res_valid), 0);
        check("reset strobes", {a_enable, acc_enable, addsub, add_ctrl,
              xor_ctrl, mul_out_ctrl}, 0);
        check("reset alu_ab", {alu_a, alu_b}, 0);
        check("reset results", {bus.res_lo, bus.res_hi}, 0);
        check("reset status err", {bus.res_status, bus.res_err}, 0);
        check("reset op_count", 32'(op_count), 0);
        repeat (2) @(negedge clk);
        rst = 1;
        #1 check("ready before edge", 32'(bus.instr_ready), 0);
        @(posedge clk); #1;
        check("ready after release", 32'(bus.instr_ready), 1);

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold,
                   vecs[i].lo, vecs[i].hi, vecs[i].err, $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            rop = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3))
                                             : 3'($urandom_range(4, 7));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i < 4) rb = (i < 2) ? 16'd0 : ra;
            ref_op(rop, ra, rb, r_lo, r_hi, r_st, r_err);
            run_op(rop, ra, rb, $urandom_range(0, 3), r_lo, r_hi, r_err,
                   $sformatf("rnd%0d", i));
        end

        // asynchronous reset in the middle of EXEC
        bus.instr_valid = 1; bus.opcode = 3'd0;
        bus.op_a = 16'd9; bus.op_b = 16'd9;
        @(posedge clk); #1;
        bus.instr_valid = 0;
        @(posedge clk); #1;
        check("mid-op in EXEC", 32'(acc_enable), 1);
        #3 rst = 0;
        #1;
        check("async strobes", {a_enable, acc_enable, addsub, add_ctrl,
              xor_ctrl, mul_out_ctrl}, 0);
        check("async res_valid", 32'(bus.res_valid), 0);
        check("async alu_b", 32'(alu_b), 0);
        check("async op_count", 32'(op_count), 0);
        check("async instr_ready", 32'(bus.instr_ready), 0);
        exp_count = 0;
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        check("ready after async", 32'(bus.instr_ready), 1);
        run_op(3'd0, 16'd1, 16'd1, 1, 16'h0002, 16'h0000, 1'b0, "post-reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Upstream control stage for the 16-bit ALU datapath (A register, adder/subtractor, XOR, multiplier, accumulator pair, status encoder).
- Accepts one operation per valid/ready handshake and sequences the ALU strobes over fixed cycles.
- Captures the accumulator outputs and status into result registers, then presents them on a valid/ready result port.
- Also keeps a count of completed operations.

Parameters:
- WIDTH, 16, datapath width; only 16 is supported.
- OPW, 3, opcode width.
- CNT_W, 16, completed-operation counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- instr_valid  in  1  operation request.
- instr_ready  out  1  sequencer can accept an operation.
- opcode  in  OPW  operation: 000 ADD, 001 SUB, 010 XOR, 011 MUL; others illegal.
- op_a  in  WIDTH  first operand.
- op_b  in  WIDTH  second operand.
- alu_a  out  WIDTH  drives ALU a.
- alu_b  out  WIDTH  drives ALU b.
- a_enable  out  1  ALU A-register load.
- acc_enable  out  1  ALU accumulator load.
- addsub  out  1  1 = subtract.
- add_ctrl  out  1  adder output onto the accumulator bus.
- xor_ctrl  out  1  XOR output onto the accumulator bus.
- mul_out_ctrl  out  1  multiplier upper half onto the accumulator bus.
- acc_out  in  WIDTH  ALU accumulator.
- mul_acc_out  in  WIDTH  ALU multiplier accumulator (lower half).
- status_reg  in  4  ALU status flags (combinational from the adder).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_lo  out  WIDTH  result low word.
- res_hi  out  WIDTH  result high word.
- res_status  out  4  captured status.
- res_err  out  1  illegal opcode.
- op_count  out  CNT_W  completed operations.

Behaviour:
- Reset:
  - rst low immediately forces state IDLE and all outputs to 0, with no clock required. This includes op_count, the result registers and every ALU strobe.
  - Reset mid-operation abandons the operation with no result.
  - instr_ready rises in the first cycle after rst deasserts.
- States:
  - IDLE -> LOAD -> EXEC -> CAPT -> RESP -> IDLE.
  - IDLE -> RESP directly for an illegal opcode.
- IDLE:
  - instr_ready=1.
  - Handshake when instr_valid & instr_ready at a clock edge: latch opcode, op_a, op_b internally.
  - opcode, op_a and op_b are ignored outside the handshake.
- LOAD (1 cycle):
  - a_enable=1, alu_a=latched op_a.
  - All other strobes 0, alu_b=0.
- EXEC (1 cycle):
  - alu_b=latched op_b, acc_enable=1.
  - Exactly one of add_ctrl / xor_ctrl / mul_out_ctrl =1.
  - addsub=1 only for SUB; add_ctrl=1 for both ADD and SUB.
  - status_reg is sampled at the end of this cycle into res_status for ADD/SUB; res_status=0 for XOR/MUL.
- CAPT (1 cycle):
  - All strobes 0.
  - res_lo <= acc_out for ADD/SUB/XOR; res_lo <= mul_acc_out for MUL.
  - res_hi <= acc_out for MUL, else 0.
- RESP:
  - res_valid=1.
  - res_lo, res_hi, res_status and res_err are held stable until res_valid & res_ready at an edge, then return to IDLE.
  - op_count increments by 1 on that edge and wraps at 2^CNT_W.
- Illegal opcode:
  - No ALU strobes.
  - Next cycle enters RESP with res_err=1, res_lo=res_hi=res_status=0.
  - The operation still counts in op_count.
- Strobe exclusivity:
  - a_enable, acc_enable and the bus strobes are all 0 outside LOAD/EXEC.
  - At most one bus strobe is high in any cycle.
  - alu_a holds its last value outside LOAD; alu_b=0 outside EXEC.
- Timing:
  - Latency from accepting edge to res_valid high is 4 clocks (IDLE->LOAD->EXEC->CAPT->RESP); illegal opcodes take 1.
  - Throughput is at most one operation per 5 clocks; instr_ready=0 in all states except IDLE.
- res_err is cleared on the next accepted legal operation.

Test Plan:
- ADD, op_a=0x0003, op_b=0x0004, res_ready=1 -> res_valid 4 clocks after handshake; res_lo=0x0007, res_hi=0, res_err=0; op_count=1.
- SUB, op_a=0x0005, op_b=0x0007 -> addsub=1 only during EXEC; res_lo=0xFFFE, res_status equals status_reg sampled in EXEC.
- XOR 0xF0F0 ^ 0x0FF0 -> res_lo=0xFF00; MUL 0x0100 * 0x0100 -> res_hi=0x0001, res_lo=0x0000, mul_out_ctrl high exactly 1 cycle.
- Backpressure: res_ready=0 for 10 cycles after res_valid -> results stable, instr_ready=0, a new instr_valid ignored; res_ready=1 -> op_count increments once, instr_ready=1 next cycle.
- opcode=111 -> no strobes; res_valid 1 clock after handshake, res_err=1, results 0; a following ADD clears res_err.
- Assert rst low during EXEC, asynchronously mid-cycle -> all strobes and res_valid drop immediately, op_count=0; after release an ADD 1+1 completes with res_lo=0x0002.
